// File: rtl/jk_reg_counter_if.sv
// Purpose: groups the mode/data inputs and state/status outputs of
// jk_reg_counter so a driver and the counter share one bundle.
//   master : enable, mode, j, k, d out; q, qbar, tc, wrap, load_err in
//   slave  : the reverse view, used by the counter itself
interface jk_reg_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output enable, mode, j, k, d,
    input  q, qbar, tc, wrap, load_err
  );

  modport slave (
    input  enable, mode, j, k, d,
    output q, qbar, tc, wrap, load_err
  );
endinterface

// File: rtl/jk_reg_counter.sv
// Purpose: WIDTH-bit bank of JK flip-flops with modulo-MOD up/down counting
// and clamped parallel load.
//   clock : rising-edge clock
//   clear : synchronous active-high reset to RESET_VAL
//   bus   : slave view of jk_reg_counter_if
//           enable/mode/j/k/d in; q (registered), qbar and tc (combinational),
//           wrap and load_err (registered one-cycle pulses) out
module jk_reg_counter #(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned MOD       = 64'd1 << WIDTH,
  parameter longint unsigned RESET_VAL = 64'd0
) (
  input  logic              clock,
  input  logic              clear,
  jk_reg_counter_if.slave   bus
);

  // One spare bit so MOD itself (up to 2**WIDTH) is representable.
  localparam int unsigned W1 = WIDTH + 1;
  localparam logic [W1-1:0] MOD_W    = W1'(MOD);
  localparam logic [W1-1:0] MOD_M1_W = W1'(MOD - 64'd1);
  localparam logic [WIDTH-1:0] MOD_M1  = WIDTH'(MOD - 64'd1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic [W1-1:0]    q_ext, d_ext;
  logic             at_top, at_zero;
  mode_e            mode;

  assign mode    = mode_e'(bus.mode);
  assign q_ext   = {1'b0, q_q};
  assign d_ext   = {1'b0, bus.d};
  // Out-of-range values left by JK writes count as "at top" for up mode.
  assign at_top  = (q_ext >= MOD_M1_W);
  assign at_zero = (q_q == '0);

  // Next-state and pulse generation.
  always_comb begin
    q_d        = q_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.enable) begin
      unique case (mode)
        MODE_JK: begin
          // Characteristic equation q+ = j&~q | ~k&q, applied bitwise.
          q_d = (bus.j & ~q_q) | (~bus.k & q_q);
        end
        MODE_UP: begin
          if (at_top) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end else begin
            q_d = WIDTH'(q_ext + W1'(1));
          end
        end
        MODE_DOWN: begin
          if (at_zero) begin
            q_d    = MOD_M1;
            wrap_d = 1'b1;
          end else begin
            q_d = WIDTH'(q_ext - W1'(1));
          end
        end
        MODE_LOAD: begin
          if (d_ext < MOD_W) begin
            q_d = bus.d;
          end else begin
            q_d        = MOD_M1;
            load_err_d = 1'b1;
          end
        end
        default: q_d = q_q;
      endcase
    end
  end

  // State register with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      q_q        <= RST_VAL;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.qbar     = ~q_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;
  // tc predicts a wrap on the next edge.
  assign bus.tc = bus.enable & (((mode == MODE_UP) & at_top) |
                                ((mode == MODE_DOWN) & at_zero));

endmodule
